// File: rtl/seq_det_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_det_pkg                                                |
// | Description : Shared constants and helpers for seq_detector_param:       |
// |               reset-time default configuration, pattern-length clamp     |
// |               and compare-mask generation.                               |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package seq_det_pkg;

  // Default configuration: the classic 1101 overlapping detector.
  localparam logic [7:0]  C_DEF_PATTERN = 8'b0000_1101;
  localparam int unsigned C_DEF_LEN     = 4;
  localparam bit          C_DEF_OVERLAP = 1'b1;

  // Width of the mask helper result. Detectors up to this many bits are
  // supported; narrower callers zero-extend their difference vector.
  localparam int unsigned MASK_W = 64;

  // Requested lengths beyond the history depth are clamped to the depth.
  // A length of zero passes through unchanged and disables detection.
  function automatic int unsigned clamp_len(input int unsigned req_len,
                                            input int unsigned max_len);
    return (req_len > max_len) ? max_len : req_len;
  endfunction

  // Mask with the low 'len' bits set.
  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sat_counter                                                |
// | Description : Up-counter that saturates at all-ones. Clear has priority  |
// |               over increment.                                            |
// | Ports       : clk   - clock, rising edge                                 |
// |               reset - synchronous active-high reset to 0                 |
// |               inc   - increment by one unless saturated                  |
// |               clr   - synchronous clear to 0 (wins over inc)             |
// |               count - current count                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_MAX = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != C_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_detector_param                                         |
// | Description : Runtime-programmable serial sequence detector with         |
// |               registered (Moore) match flag, overlap selection, input    |
// |               qualifier and saturating match counter.                    |
// | Ports       : clk         - clock, rising edge                           |
// |               reset       - synchronous active-high reset                |
// |               x, x_valid  - serial bit and its qualifier                 |
// |               cfg_load    - strobe: latch pattern/pat_len/overlap        |
// |               pattern     - pattern[pat_len-1] is the first bit received |
// |               pat_len     - pattern length (0 disables, >MAX_LEN clamps) |
// |               overlap     - 1 overlapping, 0 non-overlapping detection   |
// |               cnt_clr     - clear match counter                          |
// |               y           - one-cycle match flag                         |
// |               match_count - saturating match count                       |
// |               armed       - history holds at least the active length     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        LEN_W       = 4,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(C_DEF_PATTERN),
  parameter int unsigned        DEF_LEN     = C_DEF_LEN,
  parameter bit                 DEF_OVERLAP = C_DEF_OVERLAP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  localparam logic [LEN_W-1:0] C_MAX_FILL = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] C_RST_LEN  = LEN_W'(clamp_len(DEF_LEN, MAX_LEN));

  // Only the previous MAX_LEN-1 bits are stored: together with the incoming
  // bit they form the full MAX_LEN-bit compare window, so the oldest bit of
  // a MAX_LEN-deep shifter would never be looked at.
  logic [MAX_LEN-2:0] r_hist;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_fill;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_y;
  logic               r_armed;

  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [LEN_W-1:0]   w_fill_next;
  logic [LEN_W-1:0]   w_eff_len;
  logic [MASK_W-1:0]  w_diff_ext;
  logic               w_full;
  logic               w_match;
  logic               w_armed_next;
  logic               w_cnt_inc;

  always_comb begin
    w_hist_next = {r_hist, x};
    w_fill_inc  = (r_fill >= C_MAX_FILL) ? r_fill : r_fill + LEN_W'(1);

    // Enough bits seen once the incoming one is counted; one extra bit of
    // width keeps fill+1 from wrapping when fill already equals MAX_LEN.
    w_full = ({1'b0, r_fill} + (LEN_W+1)'(1)) >= {1'b0, r_len};

    // Bits of the window that differ from the pattern, zero-extended so the
    // shared mask helper can select the active low 'len' bits.
    w_diff_ext                = '0;
    w_diff_ext[MAX_LEN-1:0]   = w_hist_next ^ r_pat;

    w_match = x_valid && (r_len != '0) && w_full &&
              ((w_diff_ext & len_mask(32'(r_len))) == '0);

    // Non-overlapping mode forgets the bits consumed by a match.
    w_fill_next = r_fill;
    if (x_valid) begin
      w_fill_next = (w_match && !r_overlap) ? '0 : w_fill_inc;
    end

    w_armed_next = (r_len != '0) && (w_fill_next >= r_len);
    w_eff_len    = LEN_W'(clamp_len(32'(pat_len), MAX_LEN));

    // A cfg_load cycle discards its x bit, so it can never count a match.
    w_cnt_inc = w_match && !cfg_load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pat     <= DEF_PATTERN;
      r_len     <= C_RST_LEN;
      r_overlap <= DEF_OVERLAP;
      r_y       <= 1'b0;
      r_armed   <= 1'b0;
    end else if (cfg_load) begin
      r_pat     <= pattern;
      r_len     <= w_eff_len;
      r_overlap <= overlap;
      r_hist    <= '0;
      r_fill    <= '0;
      r_y       <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_y     <= w_match;
      r_armed <= w_armed_next;
      r_fill  <= w_fill_next;
      if (x_valid) begin
        r_hist <= w_hist_next[MAX_LEN-2:0];
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_cnt_inc),
    .clr   (cnt_clr),
    .count (match_count)
  );

  assign y     = r_y;
  assign armed = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_seq_detector_param                                      |
// | Description : Scoreboard bench for seq_detector_param. Two instances     |
// |               share all inputs: one with an 8-bit counter, one with a    |
// |               2-bit counter for saturation behaviour.                    |
// | Ports       : none                                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] pat_len = '0;
  logic       overlap = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       y, armed, y2, armed2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
    .y(y), .match_count(match_count), .armed(armed)
  );

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
    .y(y2), .match_count(match_count2), .armed(armed2)
  );

  // Expected state after one clock edge; -1 skips a field.
  typedef struct {
    logic  y;
    int    cnt;
    int    arm;
    int    cnt2;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // ---------------------------------------------------------------- monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (y !== e.y) begin
          n_fail++;
          $display("FAIL %s y: got %b expected %b", e.nm, y, e.y);
        end
        if (e.cnt >= 0) begin
          n_checks++;
          if (int'(match_count) != e.cnt) begin
            n_fail++;
            $display("FAIL %s match_count: got %0d expected %0d", e.nm, match_count, e.cnt);
          end
        end
        if (e.arm >= 0) begin
          n_checks++;
          if (int'(armed) != e.arm) begin
            n_fail++;
            $display("FAIL %s armed: got %b expected %0d", e.nm, armed, e.arm);
          end
        end
        if (e.cnt2 >= 0) begin
          n_checks++;
          if (int'(match_count2) != e.cnt2) begin
            n_fail++;
            $display("FAIL %s match_count(CNT_W=2): got %0d expected %0d", e.nm, match_count2, e.cnt2);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  // Apply one cycle of x/x_valid (plus any strobes already set), then queue
  // what the outputs must show after that edge.
  task automatic cyc(input logic bx, input logic bv, input logic ey,
                     input int ec, input int ea, input int ec2, input string nm);
    exp_t e;
    x       = bx;
    x_valid = bv;
    @(posedge clk);
    e.y = ey; e.cnt = ec; e.arm = ea; e.cnt2 = ec2; e.nm = nm;
    sb.push_back(e);
    #1;
    reset    = 1'b0;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    pattern  = p;
    pat_len  = l;
    overlap  = o;
    cfg_load = 1'b1;
  endtask

  // Directed stream 1,1,0,1,1,0,1 and hand-derived responses.
  int s_b[7]    = '{1, 1, 0, 1, 1, 0, 1};
  int t1_y[7]   = '{0, 0, 0, 1, 0, 0, 1};
  int t1_c[7]   = '{0, 0, 0, 1, 1, 1, 2};
  int t1_a[7]   = '{0, 0, 0, 1, 1, 1, 1};
  int t2_y[7]   = '{0, 0, 0, 1, 0, 0, 0};
  int t2_a[7]   = '{0, 0, 0, 0, 0, 0, 0};
  int t5_c[8]   = '{0, 1, 2, 3, 4, 5, 0, 1};
  int t5_c2[8]  = '{0, 1, 1, 3, 3, 3, 0, 1};

  // Reference model for the long random run.
  logic [7:0] m_pat;
  logic       m_ovl;
  int         mq[$];
  int         m_cnt, m_cnt2;

  function automatic bit model_push(input int b);
    bit hit;
    mq.push_back(b);
    if (mq.size() > 8) void'(mq.pop_front());
    if (mq.size() < 8) return 1'b0;
    hit = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (mq[i] != int'(m_pat[7-i])) hit = 1'b0;
    end
    if (hit && !m_ovl) mq.delete();
    return hit;
  endfunction

  initial begin
    logic [14:0] inj;
    int          b, v, k;
    bit          hit;

    t5_c2[2] = 2;

    // 1: reset defaults (1101, overlapping)
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, "reset");
    for (int i = 0; i < 7; i++)
      cyc(1'(s_b[i]), 1'b1, 1'(t1_y[i]), t1_c[i], t1_a[i], t1_c[i], "t1_ovl");
    cyc(1'b1, 1'b0, 1'b0, 2, 1, 2, "t1_idle");

    // 2: non-overlapping; the x bit of the cfg_load cycle is discarded
    cfg(8'b0000_1101, 4'd4, 1'b0);
    cnt_clr = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 0, "t2_cfg");
    for (int i = 0; i < 7; i++)
      cyc(1'(s_b[i]), 1'b1, 1'(t2_y[i]), (i >= 3) ? 1 : 0, t2_a[i], (i >= 3) ? 1 : 0, "t2_novl");

    // 3: gaps of three invalid cycles between bits
    cfg(8'b0000_1101, 4'd4, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1, 0, 1, "t3_cfg");
    for (int i = 0; i < 4; i++) begin
      cyc(1'(s_b[i]), 1'b1, (i == 3), (i == 3) ? 2 : 1, (i == 3) ? 1 : 0, (i == 3) ? 2 : 1, "t3_bit");
      for (int g = 0; g < 3; g++)
        cyc(~1'(s_b[i]), 1'b0, 1'b0, (i == 3) ? 2 : 1, (i == 3) ? 1 : 0, (i == 3) ? 2 : 1, "t3_gap");
    end

    // 4: reset mid-pattern, clamp of long length, zero length
    cfg(8'b0000_1101, 4'd4, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 2, 0, 2, "t4_cfg");
    cyc(1'b1, 1'b1, 1'b0, 2, 0, 2, "t4_pre");
    cyc(1'b1, 1'b1, 1'b0, 2, 0, 2, "t4_pre");
    cyc(1'b0, 1'b1, 1'b0, 2, 0, 2, "t4_pre");
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 0, "t4_reset");
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 0, "t4_post_rst");
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 0, "t4_refill");
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 0, "t4_refill");
    cyc(1'b0, 1'b1, 1'b0, 0, 1, 0, "t4_refill");
    cyc(1'b1, 1'b1, 1'b1, 1, 1, 1, "t4_match");
    cfg(8'b1011_0011, 4'd9, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1, 0, 1, "t4_len9_cfg");
    m_pat = 8'b1011_0011;
    for (int i = 7; i >= 0; i--)
      cyc(m_pat[i], 1'b1, (i == 0), (i == 0) ? 2 : 1, (i == 0) ? 1 : 0, (i == 0) ? 2 : 1, "t4_len9");
    cfg(8'b0000_0000, 4'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 2, 0, 2, "t4_len0_cfg");
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, 1'b0, 2, 0, 2, "t4_len0");

    // 5: saturation of the 2-bit counter, clear beats a simultaneous match
    cfg(8'b0000_0011, 4'd2, 1'b1);
    cnt_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, "t5_cfg");
    for (int i = 0; i < 8; i++) begin
      if (i == 6) cnt_clr = 1'b1;
      cyc(1'b1, 1'b1, (i != 0), t5_c[i], (i != 0) ? 1 : 0, t5_c2[i], "t5_sat");
    end

    // 6: long random stream against the model, both overlap modes.
    // Every 300 bits a pattern-plus-overlapped-pattern burst is injected.
    inj = 15'b101100110110011;
    for (int mode = 1; mode >= 0; mode--) begin
      m_pat = 8'b1011_0011;
      m_ovl = 1'(mode);
      mq.delete();
      m_cnt  = 0;
      m_cnt2 = 0;
      cfg(m_pat, 4'd8, m_ovl);
      cnt_clr = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, "t6_cfg");
      for (int i = 0; i < 2000; i++) begin
        k = i % 300;
        if (k < 15) begin
          b = int'(inj[14-k]);
          v = 1;
        end else begin
          b = int'($urandom_range(0, 1));
          v = ($urandom_range(0, 9) != 0) ? 1 : 0;
        end
        hit = (v != 0) ? model_push(b) : 1'b0;
        if (hit && m_cnt < 255) m_cnt++;
        if (hit && m_cnt2 < 3)  m_cnt2++;
        cyc(1'(b), 1'(v), hit, m_cnt, (mq.size() >= 8) ? 1 : 0, m_cnt2,
            m_ovl ? "t6_rand_ovl" : "t6_rand_novl");
      end
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
